// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, default latencies, pending-result type
// and the divide helper used by mdu_unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MADD  = 3'd6,
    MDU_MADDU = 3'd7
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int MDU_CNT_W       = 4;

  // we=0 marks a result that must not be written at commit (divide by zero)
  typedef struct packed {
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  // Works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
  function automatic mdu_res_t mdu_divide(logic [31:0] a, logic [31:0] b, logic sgn);
    mdu_res_t    r;
    logic        neg_a, neg_b;
    logic [31:0] ua, ub, q, rm;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ua    = neg_a ? -a : a;
    ub    = neg_b ? -b : b;
    r     = '0;
    if (b != 32'd0) begin
      q    = ua / ub;
      rm   = ua % ub;
      r.we = 1'b1;
      r.lo = (neg_a ^ neg_b) ? -q : q;
      r.hi = neg_a ? -rm : rm;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Execute-stage request/response bundle between the pipeline and the MDU.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_timer.sv
// Loadable down-counter: busy while counting, fire in the cycle the count is zero.
module mdu_timer
  import mdu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [MDU_CNT_W-1:0] load_val,
  output logic                 busy,
  output logic                 fire
);

  logic [MDU_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end else if (load) begin
      cnt  <= load_val;
      busy <= 1'b1;
    end
  end

  assign fire = busy && (cnt == '0);

endmodule

// File: rtl/mdu_unit.sv
// MIPS multiply/divide unit owning HI/LO. Result is computed at accept and held
// until the fixed latency expires. Define MDU_MADD_EN to enable MADD/MADDU (ops 6/7).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam logic [MDU_CNT_W-1:0] MUL_LAT = MDU_CNT_W'(MULT_CYCLES - 1);
  localparam logic [MDU_CNT_W-1:0] DIV_LAT = MDU_CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state;
  mdu_op_e     op;
  logic        is_mul, is_div, sgn, accept;
  logic        busy, fire, done_q;
  logic [63:0] prod;
  logic [31:0] hi_q, lo_q;
  mdu_res_t    res, tmp;

  assign op = mdu_op_e'(bus.op);

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    sgn    = 1'b0;
    case (op)
      MDU_MULT:  begin is_mul = 1'b1; sgn = 1'b1; end
      MDU_MULTU: is_mul = 1'b1;
      MDU_DIV:   begin is_div = 1'b1; sgn = 1'b1; end
      MDU_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD:  begin is_mul = 1'b1; sgn = 1'b1; end
      MDU_MADDU: is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  // One 64x64 multiply covers both signednesses; the low 64 bits are exact.
  assign prod = {{32{sgn & bus.a[31]}}, bus.a} * {{32{sgn & bus.b[31]}}, bus.b};

  always_comb begin
    res = '{we: 1'b1, hi: prod[63:32], lo: prod[31:0]};
    if (is_div) res = mdu_divide(bus.a, bus.b, sgn);
`ifdef MDU_MADD_EN
    if (op == MDU_MADD || op == MDU_MADDU) {res.hi, res.lo} = {hi_q, lo_q} + prod;
`endif
  end

  assign accept = bus.start && (state == IDLE) && (is_mul || is_div);

  mdu_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (is_div ? DIV_LAT : MUL_LAT),
    .busy     (busy),
    .fire     (fire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      tmp    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tmp   <= res;
            state <= RUN;
          end else if (bus.start && op == MDU_MTHI) begin
            hi_q <= bus.a;
          end else if (bus.start && op == MDU_MTLO) begin
            lo_q <= bus.a;
          end
        end
        RUN: begin
          if (fire) begin
            state  <= IDLE;
            done_q <= 1'b1;
            if (tmp.we) begin
              hi_q <= tmp.hi;
              lo_q <= tmp.lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
